ksa_addsub_pipe: RTL and testbench
==================================

// Module: ksa_addsub_pipe
// PURPOSE
//  Parametrised successor to the team's fixed-latency Kogge-Stone pipe.
//  Pipelined Kogge-Stone add/subtract unit for the datapath arithmetic cluster.
//  - Pipeline registers can be placed every REG_EVERY prefix levels.
//  - Valid/ready handshake with back-pressure.
//  - Per-operation add/sub mode, signed overflow flag, sideband tag.
// PARAMETERS
//  BITS       64  operand width
//  LEVELS     6   prefix levels; must equal ceil(log2(BITS))
//  REG_EVERY  2   register after every REG_EVERY prefix levels (1..LEVELS)
//  TAG_W      4   sideband tag width, passed through unchanged
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        async active-low reset
//  in_valid   in   1        operand beat valid
//  in_ready   out  1        unit accepts beat this cycle
//  a          in   BITS     operand A
//  b          in   BITS     operand B
//  cin        in   1        carry-in (add mode only)
//  sub        in   1        1: compute a-b; 0: compute a+b+cin
//  tag_in     in   TAG_W    sideband, travels with the beat
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  s          out  BITS+1   {carry_out, sum[BITS-1:0]}
//  ovf        out  1        two's-complement overflow of sum
//  tag_out    out  TAG_W    tag of the beat on s
// BEHAVIOUR
//  Reset
//  - rst_n low asynchronously clears every valid bit, s, ovf and tag_out to 0.
//  - in_ready is 1 while in reset and after reset.
//  - Beats in flight when reset asserts are discarded, never emitted.
//  Structure
//  - Stage 0 registers a, b' = sub ? ~b : b, c0 = sub ? 1 : cin, sub, tag.
//  - PG generation: P = a^b', G = a&b'.
//  - Level k combines span 2**(k-1); bit i takes (i - 2**(k-1)) as for a
//    standard Kogge-Stone; bits below 2**(k-1) pass through.
//  - c0 is folded in as G[-1], so carry into bit i = Gfinal[i-1]
//    (c0 for bit 0).
//  - Register stage after level k when k % REG_EVERY == 0 and k < LEVELS.
//    Each such stage carries P0, current P/G, c0, sub and tag.
//  - Output register holds s, ovf, tag_out.
//  - Latency from accept to out_valid: LAT = 2 + floor((LEVELS-1)/REG_EVERY)
//    cycles. Defaults give LAT = 4.
//  Arithmetic
//  - sum[i] = P0[i] ^ carry_in[i].
//  - s[BITS] = carry out of bit BITS-1. In sub mode, s[BITS] = 1 means
//    no borrow (a >= b unsigned).
//  - ovf = carry_in[BITS-1] ^ s[BITS].
//  - cin is ignored when sub = 1.
//  Handshake
//  - Single global advance: adv = !out_valid | out_ready.
//  - All stages shift together when adv = 1 and hold when adv = 0.
//  - in_ready = adv (combinational from out_valid and out_ready).
//  - A beat is accepted when in_valid & in_ready. When adv = 1 and
//    in_valid = 0, a bubble (valid = 0) enters.
//  - out_valid, s, ovf and tag_out are stable while out_valid & !out_ready.
//  - Full throughput: 1 beat/cycle when out_ready is held at 1.
//  - Beats are delivered in order. None are dropped or duplicated.
//  - Bubbles are not compressed: a stall freezes bubbles in place.
// TESTING (BITS=64, LEVELS=6, REG_EVERY=2, LAT=4)
//  1. Reset mid-stream: 3 beats in flight, pulse rst_n low -> out_valid=0, s=0
//     at once; no stale result after release.
//  2. Add: a=FFFF_FFFF_FFFF_FFFF, b=1, cin=0, tag=5 -> 4 cycles later
//     s=1_0000_0000_0000_0000, ovf=0, tag_out=5.
//  3. Sub: a=0, b=1, sub=1, cin=1 -> s={0, FFFF_FFFF_FFFF_FFFF}, ovf=0
//     (cin ignored).
//  4. Overflow: a=7FFF_FFFF_FFFF_FFFF, b=1, add -> sum=8000_0000_0000_0000,
//     ovf=1, s[64]=0.
//  5. Back-pressure: 8 back-to-back beats, out_ready low for cycles 5-7 ->
//     in_ready low in the same cycles, outputs held, all 8 results in order.
//  6. Random: 10k beats, random add/sub/cin/tag/out_ready, REG_EVERY in
//     {1,2,6} -> results match the reference model (a +/- b), tags in order.

Source files
------------

// File: rtl/ksa_addsub_pipe.sv
// ============================================================================
// ksa_addsub_pipe : pipelined Kogge-Stone add/sub with valid/ready handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module ksa_addsub_pipe #(
   parameter int BITS      = 64,
   parameter int LEVELS    = 6,
   parameter int REG_EVERY = 2,
   parameter int TAG_W     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BITS-1:0]  a,
   input  logic [BITS-1:0]  b,
   input  logic             cin,
   input  logic             sub,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BITS:0]    s,
   output logic             ovf,
   output logic [TAG_W-1:0] tag_out
);

   // Number of mid-prefix register stages; segment r spans the levels between them.
   localparam int NSTG = (LEVELS - 1) / REG_EVERY;

   logic adv;

   logic [BITS-1:0]  a_q, a_d, bx_q, bx_d;
   logic             c0_q, c0_d, vld0_q, vld0_d;
   logic [TAG_W-1:0] tag0_q, tag0_d;

   logic             out_valid_q, out_valid_d, ovf_q, ovf_d;
   logic [BITS:0]    s_q, s_d;
   logic [TAG_W-1:0] tag_out_q, tag_out_d;

   logic [BITS-1:0]  seg_p   [NSTG+1];
   logic [BITS-1:0]  seg_g   [NSTG+1];
   logic [BITS-1:0]  seg_p0  [NSTG+1];
   logic             seg_c0  [NSTG+1];
   logic             seg_vld [NSTG+1];
   logic [TAG_W-1:0] seg_tag [NSTG+1];
   logic [BITS-1:0]  lvl_p   [NSTG+1];
   logic [BITS-1:0]  lvl_g   [NSTG+1];

   logic [BITS-1:0]  pg_p, pg_g, carry_in;

   assign adv       = !out_valid_q || out_ready;
   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign s         = s_q;
   assign ovf       = ovf_q;
   assign tag_out   = tag_out_q;

   always_comb begin
      a_d    = a_q;
      bx_d   = bx_q;
      c0_d   = c0_q;
      tag0_d = tag0_q;
      vld0_d = vld0_q;
      if (adv) begin
         a_d    = a;
         bx_d   = sub ? ~b : b;
         c0_d   = sub | cin;
         tag0_d = tag_in;
         vld0_d = in_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         bx_q   <= '0;
         c0_q   <= 1'b0;
         tag0_q <= '0;
         vld0_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         bx_q   <= bx_d;
         c0_q   <= c0_d;
         tag0_q <= tag0_d;
         vld0_q <= vld0_d;
      end
   end

   // Carry-in folded into bit 0's generate so prefix G[i] is the full carry out of bit i.
   always_comb begin
      pg_p    = a_q ^ bx_q;
      pg_g    = a_q & bx_q;
      pg_g[0] = pg_g[0] | (pg_p[0] & c0_q);
   end

   for (genvar r = 0; r <= NSTG; r++) begin : g_seg
      localparam int K_LO = r * REG_EVERY + 1;
      localparam int K_HI = ((r + 1) * REG_EVERY < LEVELS) ? (r + 1) * REG_EVERY : LEVELS;

      logic [BITS-1:0] p_t, g_t;

      if (r == 0) begin : g_src
         assign seg_p[r]   = pg_p;
         assign seg_g[r]   = pg_g;
         assign seg_p0[r]  = pg_p;
         assign seg_c0[r]  = c0_q;
         assign seg_vld[r] = vld0_q;
         assign seg_tag[r] = tag0_q;
      end else begin : g_reg
         logic [BITS-1:0]  p_q, p_d, g_q, g_d, p0_q, p0_d;
         logic             c0s_q, c0s_d, vld_q, vld_d;
         logic [TAG_W-1:0] tag_q, tag_d;

         always_comb begin
            p_d   = p_q;
            g_d   = g_q;
            p0_d  = p0_q;
            c0s_d = c0s_q;
            vld_d = vld_q;
            tag_d = tag_q;
            if (adv) begin
               p_d   = lvl_p[r-1];
               g_d   = lvl_g[r-1];
               p0_d  = seg_p0[r-1];
               c0s_d = seg_c0[r-1];
               vld_d = seg_vld[r-1];
               tag_d = seg_tag[r-1];
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               p_q   <= '0;
               g_q   <= '0;
               p0_q  <= '0;
               c0s_q <= 1'b0;
               vld_q <= 1'b0;
               tag_q <= '0;
            end else begin
               p_q   <= p_d;
               g_q   <= g_d;
               p0_q  <= p0_d;
               c0s_q <= c0s_d;
               vld_q <= vld_d;
               tag_q <= tag_d;
            end
         end

         assign seg_p[r]   = p_q;
         assign seg_g[r]   = g_q;
         assign seg_p0[r]  = p0_q;
         assign seg_c0[r]  = c0s_q;
         assign seg_vld[r] = vld_q;
         assign seg_tag[r] = tag_q;
      end

      // Span doubles per level; bits below the span keep their P/G unchanged.
      always_comb begin
         p_t = seg_p[r];
         g_t = seg_g[r];
         for (int k = K_LO; k <= K_HI; k++) begin
            g_t = g_t | (p_t & (g_t << (1 << (k - 1))));
            p_t = p_t & ((p_t << (1 << (k - 1))) | ~({BITS{1'b1}} << (1 << (k - 1))));
         end
      end

      assign lvl_p[r] = p_t;
      assign lvl_g[r] = g_t;
   end

   assign carry_in = {lvl_g[NSTG][BITS-2:0], seg_c0[NSTG]};

   always_comb begin
      out_valid_d = out_valid_q;
      s_d         = s_q;
      ovf_d       = ovf_q;
      tag_out_d   = tag_out_q;
      if (adv) begin
         out_valid_d = seg_vld[NSTG];
         s_d         = {lvl_g[NSTG][BITS-1], seg_p0[NSTG] ^ carry_in};
         ovf_d       = carry_in[BITS-1] ^ lvl_g[NSTG][BITS-1];
         tag_out_d   = seg_tag[NSTG];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         s_q         <= '0;
         ovf_q       <= 1'b0;
         tag_out_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         s_q         <= s_d;
         ovf_q       <= ovf_d;
         tag_out_q   <= tag_out_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ksa_addsub_pipe.sv
// ============================================================================
// tb_ksa_addsub_pipe : directed table, back-pressure, reset and random checks
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ksa_addsub_pipe;

   localparam int N = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        iv [N], ir [N], ci_ [N], sb_ [N], ov [N], ordy [N], ovf_ [N];
   logic [63:0] a_ [N], b_ [N];
   logic [3:0]  ti [N], to_ [N];
   logic [64:0] s_ [N];

   ksa_addsub_pipe #(.BITS(64), .LEVELS(6), .REG_EVERY(2), .TAG_W(4)) u_re2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_[0]), .b(b_[0]),
      .cin(ci_[0]), .sub(sb_[0]), .tag_in(ti[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
      .s(s_[0]), .ovf(ovf_[0]), .tag_out(to_[0]));

   ksa_addsub_pipe #(.BITS(64), .LEVELS(6), .REG_EVERY(1), .TAG_W(4)) u_re1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_[1]), .b(b_[1]),
      .cin(ci_[1]), .sub(sb_[1]), .tag_in(ti[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
      .s(s_[1]), .ovf(ovf_[1]), .tag_out(to_[1]));

   ksa_addsub_pipe #(.BITS(64), .LEVELS(6), .REG_EVERY(6), .TAG_W(4)) u_re6 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_[2]), .b(b_[2]),
      .cin(ci_[2]), .sub(sb_[2]), .tag_in(ti[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
      .s(s_[2]), .ovf(ovf_[2]), .tag_out(to_[2]));

   int n_vec = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [63:0] a;
      logic [63:0] b;
      logic        cin;
      logic        sub;
      logic [3:0]  tag;
      logic [64:0] s;
      logic        ovf;
   } vec_t;

   vec_t tbl [12];

   logic [69:0] sbq [N][64];
   int          wp [N], rp [N];
   logic [69:0] last [N];
   logic        stalled [N];

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer add/subtract; overflow from operand/result signs.
   function automatic logic [65:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                             input logic cin, input logic sub);
      logic [64:0] r;
      logic        o;
      if (sub) begin
         r[63:0] = a - b;
         r[64]   = (a >= b);
         o       = (a[63] != b[63]) && (r[63] != a[63]);
      end else begin
         r = {1'b0, a} + {1'b0, b} + {64'd0, cin};
         o = (a[63] == b[63]) && (r[63] != a[63]);
      end
      return {o, r};
   endfunction

   task automatic drive_beat(input int j, input logic [63:0] a, input logic [63:0] b,
                             input logic cin, input logic sub, input logic [3:0] tag);
      iv[j]  = 1'b1;
      a_[j]  = a;
      b_[j]  = b;
      ci_[j] = cin;
      sb_[j] = sub;
      ti[j]  = tag;
   endtask

   task automatic run_vec(input vec_t v, input int n);
      int lat;
      @(negedge clk);
      ordy[0] = 1'b1;
      drive_beat(0, v.a, v.b, v.cin, v.sub, v.tag);
      #1 check($sformatf("vec%0d_in_ready", n), ir[0], 1);
      @(negedge clk);
      iv[0] = 1'b0;
      lat = 1;
      while (!ov[0] && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check($sformatf("vec%0d_latency", n), lat, 4);
      check($sformatf("vec%0d_s", n), s_[0], v.s);
      check($sformatf("vec%0d_ovf", n), ovf_[0], v.ovf);
      check($sformatf("vec%0d_tag", n), to_[0], v.tag);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [63:0] bpa [8], bpb [8];
      logic [69:0] bpe [8];
      logic [69:0] held;
      int sent, got, seen, acc0, cyc;

      for (int j = 0; j < N; j++) begin
         iv[j] = 1'b0; ordy[j] = 1'b1; a_[j] = '0; b_[j] = '0;
         ci_[j] = 1'b0; sb_[j] = 1'b0; ti[j] = '0;
         wp[j] = 0; rp[j] = 0; stalled[j] = 1'b0; last[j] = '0;
      end

      tbl[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 4'h5, 65'h1_0000_0000_0000_0000, 1'b0};
      tbl[1]  = '{64'h0, 64'h1, 1'b1, 1'b1, 4'h3, 65'h0_FFFF_FFFF_FFFF_FFFF, 1'b0};
      tbl[2]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 4'h9, 65'h0_8000_0000_0000_0000, 1'b1};
      tbl[3]  = '{64'h0, 64'h0, 1'b0, 1'b0, 4'h0, 65'h0, 1'b0};
      tbl[4]  = '{64'h5, 64'h3, 1'b0, 1'b1, 4'h1, 65'h1_0000_0000_0000_0002, 1'b0};
      tbl[5]  = '{64'h3, 64'h5, 1'b0, 1'b1, 4'h2, 65'h0_FFFF_FFFF_FFFF_FFFE, 1'b0};
      tbl[6]  = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 4'h4, 65'h1_7FFF_FFFF_FFFF_FFFF, 1'b1};
      tbl[7]  = '{64'h1, 64'h1, 1'b1, 1'b0, 4'h6, 65'h0_0000_0000_0000_0003, 1'b0};
      tbl[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 4'h7,
                  65'h1_FFFF_FFFF_FFFF_FFFF, 1'b0};
      tbl[9]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 4'h8,
                  65'h1_0000_0000_0000_0000, 1'b1};
      tbl[10] = '{64'h0, 64'h0, 1'b0, 1'b1, 4'hA, 65'h1_0000_0000_0000_0000, 1'b0};
      tbl[11] = '{64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b0, 4'hF,
                  65'h1_0000_0000_0000_0000, 1'b0};

      // Reset state
      #1;
      check("rst_out_valid", ov[0], 0);
      check("rst_s", s_[0], 0);
      check("rst_ovf", ovf_[0], 0);
      check("rst_tag", to_[0], 0);
      for (int j = 0; j < N; j++) check($sformatf("rst_in_ready%0d", j), ir[j], 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) run_vec(tbl[i], i);

      // Back-pressure: 8 beats, out_ready low during cycles 5..7
      for (int k = 0; k < 8; k++) begin
         bpa[k] = {$urandom, $urandom};
         bpb[k] = {$urandom, $urandom};
         bpe[k] = {ref_model(bpa[k], bpb[k], 1'b1, k[0]), 4'(k + 8)};
      end
      sent = 0; got = 0; held = '0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         ordy[0] = !(c >= 5 && c <= 7);
         if (sent < 8) drive_beat(0, bpa[sent], bpb[sent], 1'b1, sent[0], 4'(sent + 8));
         else iv[0] = 1'b0;
         #1;
         check($sformatf("bp_in_ready_c%0d", c), ir[0], (c >= 5 && c <= 7) ? 0 : 1);
         if (c >= 5 && c <= 7) check($sformatf("bp_stall_valid_c%0d", c), ov[0], 1);
         if (iv[0] && ir[0]) sent++;
         if (ov[0]) begin
            if (!ordy[0]) begin
               if (c == 5) held = {ovf_[0], s_[0], to_[0]};
               else check($sformatf("bp_hold_c%0d", c), {ovf_[0], s_[0], to_[0]}, held);
            end else if (got < 8) begin
               check($sformatf("bp_result%0d", got), {ovf_[0], s_[0], to_[0]}, bpe[got]);
               got++;
            end
         end
      end
      check("bp_count", got, 8);

      // Reset with beats in flight
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         drive_beat(0, 64'(c + 100), 64'(c + 1), 1'b0, 1'b0, 4'(c + 1));
      end
      @(negedge clk);
      iv[0] = 1'b0;
      #1 check("rst_mid_pre_valid", ov[0], 1);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", ov[0], 0);
      check("rst_mid_s", s_[0], 0);
      check("rst_mid_tag", to_[0], 0);
      check("rst_mid_in_ready", ir[0], 1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         #1 if (ov[0]) seen++;
      end
      check("rst_no_stale", seen, 0);

      // Random traffic on all three pipeline depths
      acc0 = 0; cyc = 0;
      while (acc0 < 10000 && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         for (int j = 0; j < N; j++) begin
            iv[j] = ($urandom_range(3) != 0);
            a_[j] = {$urandom, $urandom};
            b_[j] = {$urandom, $urandom};
            case ($urandom_range(7))
               0: b_[j] = ~a_[j];
               1: b_[j] = a_[j];
               2: a_[j] = {1'b0, {63{1'b1}}};
               3: a_[j] = {1'b1, 63'd0};
               default: ;
            endcase
            ci_[j]  = 1'($urandom_range(1));
            sb_[j]  = 1'($urandom_range(1));
            ti[j]   = 4'($urandom);
            ordy[j] = ($urandom_range(3) != 0);
         end
         #1;
         for (int j = 0; j < N; j++) begin
            if (stalled[j]) check($sformatf("rand_hold%0d", j),
                                  {ov[j], ovf_[j], s_[j], to_[j]}, {1'b1, last[j]});
            if (ov[j] && ordy[j]) begin
               if (wp[j] == rp[j]) begin
                  n_vec++; n_bad++;
                  $display("FAIL rand_spurious%0d: out_valid=1 with no beat pending", j);
               end else begin
                  check($sformatf("rand_result%0d", j), {ovf_[j], s_[j], to_[j]}, sbq[j][rp[j][5:0]]);
                  rp[j]++;
               end
            end
            stalled[j] = ov[j] && !ordy[j];
            last[j]    = {ovf_[j], s_[j], to_[j]};
            if (iv[j] && ir[j]) begin
               sbq[j][wp[j][5:0]] = {ref_model(a_[j], b_[j], ci_[j], sb_[j]), ti[j]};
               wp[j]++;
               if (j == 0) acc0++;
            end
         end
      end
      if (acc0 < 10000) begin
         n_vec++; n_bad++;
         $display("FAIL rand_budget: accepted %0d beats, required 10000", acc0);
      end

      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         for (int j = 0; j < N; j++) begin
            iv[j] = 1'b0;
            ordy[j] = 1'b1;
         end
         #1;
         for (int j = 0; j < N; j++) begin
            if (ov[j]) begin
               if (wp[j] == rp[j]) begin
                  n_vec++; n_bad++;
                  $display("FAIL drain_spurious%0d: out_valid=1 with no beat pending", j);
               end else begin
                  check($sformatf("drain_result%0d", j), {ovf_[j], s_[j], to_[j]}, sbq[j][rp[j][5:0]]);
                  rp[j]++;
               end
            end
         end
      end
      for (int j = 0; j < N; j++) check($sformatf("drain_pending%0d", j), wp[j] - rp[j], 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
